// File: rtl/sd_drive_arbiter_pkg.sv
// rtl/sd_drive_arbiter_pkg.sv - shared state encoding and width helpers for the SD drive arbiter
package sd_drive_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_XFER = 2'd2,
    ST_DONE = 2'd3
  } arb_state_e;

  // Sector buffer geometry: 512 bytes as 512x8 or 256x16.
  function automatic int dw_of(input int wide);
    return (wide != 0) ? 15 : 7;
  endfunction

  function automatic int aw_of(input int wide);
    return (wide != 0) ? 7 : 8;
  endfunction

  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sd_drive_arbiter_rr_pick.sv
// rtl/sd_drive_arbiter_rr_pick.sv - first pending requester at or after the pointer, wrapping
module rr_pick
  import sd_drive_arbiter_pkg::*;
#(
  parameter  int NREQ = 2,
  localparam int PW   = ptr_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic            valid,
  output logic [PW-1:0]   idx
);

  // Scan from the farthest offset down so the nearest pending index wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (|(req & (NREQ'(1) << ((int'(ptr) + k) % NREQ)))) begin
        valid = 1'b1;
        idx   = PW'((int'(ptr) + k) % NREQ);
      end
    end
  end

endmodule

// File: rtl/sd_drive_arbiter.sv
// rtl/sd_drive_arbiter.sv - round-robin share of the HPS SD block channel between NREQ drives
module sd_drive_arbiter
  import sd_drive_arbiter_pkg::*;
#(
  parameter  int NREQ    = 2,
  parameter  int WIDE    = 0,
  parameter  int TIMEOUT = 0,
  localparam int DW      = dw_of(WIDE),
  localparam int AW      = aw_of(WIDE)
) (
  input  logic                   clk_sys,
  input  logic                   reset_n,
  input  logic [32*NREQ-1:0]     req_lba,
  input  logic [NREQ-1:0]        req_rd,
  input  logic [NREQ-1:0]        req_wr,
  output logic [NREQ-1:0]        req_ack,
  output logic [NREQ-1:0]        req_done,
  output logic [NREQ-1:0]        req_err,
  output logic [NREQ-1:0]        req_buff_wr,
  input  logic [(DW+1)*NREQ-1:0] req_buff_din,
  output logic [AW:0]            buff_addr,
  output logic [DW:0]            buff_dout,
  output logic [31:0]            sd_lba,
  output logic [NREQ-1:0]        sd_rd,
  output logic [NREQ-1:0]        sd_wr,
  input  logic                   sd_ack,
  input  logic [AW:0]            sd_buff_addr,
  input  logic [DW:0]            sd_buff_dout,
  input  logic                   sd_buff_wr,
  output logic [DW:0]            sd_buff_din
);

  localparam int PW = ptr_w(NREQ);

  arb_state_e      state_q, state_d;
  logic [PW-1:0]   grant_q, grant_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [31:0]     tmo_q, tmo_d;
  logic [31:0]     sd_lba_q, sd_lba_d;
  logic [NREQ-1:0] sd_rd_q, sd_rd_d;
  logic [NREQ-1:0] sd_wr_q, sd_wr_d;
  logic [NREQ-1:0] done_q, done_d;
  logic [NREQ-1:0] err_q, err_d;

  logic [31:0]     lba_arr [NREQ];
  logic [DW:0]     din_arr [NREQ];
  logic [NREQ-1:0] pend;
  logic            pick_valid;
  logic [PW-1:0]   pick_idx;
  logic [NREQ-1:0] pick_oh;
  logic [NREQ-1:0] grant_oh;
  logic [PW-1:0]   ptr_inc;
  logic            g_active;
  logic            active;

  for (genvar i = 0; i < NREQ; i++) begin : g_slice
    assign lba_arr[i] = req_lba[32*i +: 32];
    assign din_arr[i] = req_buff_din[(DW+1)*i +: DW+1];
  end

  assign pend = req_rd | req_wr;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req   (pend),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign pick_oh  = NREQ'(1) << pick_idx;
  assign grant_oh = NREQ'(1) << grant_q;
  assign ptr_inc  = (grant_q == PW'(NREQ - 1)) ? '0 : grant_q + 1'b1;
  assign g_active = req_rd[grant_q] | req_wr[grant_q];
  assign active   = (state_q != ST_IDLE);

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    ptr_d    = ptr_q;
    tmo_d    = tmo_q;
    sd_rd_d  = sd_rd_q;
    sd_wr_d  = sd_wr_q;
    sd_lba_d = sd_lba_q;
    done_d   = '0;
    err_d    = '0;
    case (state_q)
      ST_IDLE: begin
        // A stale ack from the previous transfer must clear before the next grant.
        if (pick_valid && !sd_ack) begin
          grant_d  = pick_idx;
          sd_lba_d = lba_arr[pick_idx];
          tmo_d    = '0;
          if (req_rd[pick_idx]) sd_rd_d = pick_oh;
          else                  sd_wr_d = pick_oh;
          state_d  = ST_REQ;
        end
      end
      ST_REQ: begin
        if (sd_ack) begin
          sd_rd_d = '0;
          sd_wr_d = '0;
          state_d = ST_XFER;
        end else if (!g_active) begin
          sd_rd_d = '0;
          sd_wr_d = '0;
          state_d = ST_IDLE;
        end else if ((TIMEOUT != 0) && (tmo_q == 32'(TIMEOUT))) begin
          sd_rd_d = '0;
          sd_wr_d = '0;
          err_d   = grant_oh;
          ptr_d   = ptr_inc;
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_q + 32'd1;
        end
      end
      ST_XFER: begin
        if (!sd_ack) begin
          done_d  = grant_oh;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        ptr_d   = ptr_inc;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      ptr_q    <= '0;
      tmo_q    <= '0;
      sd_lba_q <= '0;
      sd_rd_q  <= '0;
      sd_wr_q  <= '0;
      done_q   <= '0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      ptr_q    <= ptr_d;
      tmo_q    <= tmo_d;
      sd_lba_q <= sd_lba_d;
      sd_rd_q  <= sd_rd_d;
      sd_wr_q  <= sd_wr_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign sd_rd       = sd_rd_q;
  assign sd_wr       = sd_wr_q;
  assign sd_lba      = sd_lba_q;
  assign req_done    = done_q;
  assign req_err     = err_q;
  assign req_ack     = (active && sd_ack) ? grant_oh : '0;
  assign req_buff_wr = (active && sd_buff_wr) ? grant_oh : '0;
  assign sd_buff_din = active ? din_arr[grant_q] : '0;
  assign buff_addr   = sd_buff_addr;
  assign buff_dout   = sd_buff_dout;

endmodule

// File: tb/tb_sd_drive_arbiter.sv
// tb/tb_sd_drive_arbiter.sv - self-checking bench for sd_drive_arbiter acting as the HPS host
module tb_sd_drive_arbiter;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic [63:0] req_lba;
  logic [1:0]  req_rd, req_wr;
  logic [1:0]  req_ack, req_done, req_err, req_buff_wr;
  logic [15:0] req_buff_din;
  logic [8:0]  buff_addr;
  logic [7:0]  buff_dout;
  logic [31:0] sd_lba;
  logic [1:0]  sd_rd, sd_wr;
  logic        sd_ack;
  logic [8:0]  sd_buff_addr;
  logic [7:0]  sd_buff_dout;
  logic        sd_buff_wr;
  logic [7:0]  sd_buff_din;

  int total = 0;
  int bad   = 0;
  int ptr_m = 0;
  logic [31:0] lba_m [2];
  logic mon_en = 1'b0;

  always #5 clk_sys = ~clk_sys;

  sd_drive_arbiter #(.NREQ(2), .WIDE(0), .TIMEOUT(16)) dut (
    .clk_sys      (clk_sys),
    .reset_n      (reset_n),
    .req_lba      (req_lba),
    .req_rd       (req_rd),
    .req_wr       (req_wr),
    .req_ack      (req_ack),
    .req_done     (req_done),
    .req_err      (req_err),
    .req_buff_wr  (req_buff_wr),
    .req_buff_din (req_buff_din),
    .buff_addr    (buff_addr),
    .buff_dout    (buff_dout),
    .sd_lba       (sd_lba),
    .sd_rd        (sd_rd),
    .sd_wr        (sd_wr),
    .sd_ack       (sd_ack),
    .sd_buff_addr (sd_buff_addr),
    .sd_buff_dout (sd_buff_dout),
    .sd_buff_wr   (sd_buff_wr),
    .sd_buff_din  (sd_buff_din)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk_sys) begin
    if (mon_en && reset_n)
      check_eq("onehot_strobe", 32'($countones(sd_rd | sd_wr) <= 1), 32'd1);
  end

  task automatic drive_lba();
    req_lba = {lba_m[1], lba_m[0]};
  endtask

  // Round-robin choice from the pending set, taken straight from the arbitration rule.
  function automatic int model_pick(input logic [1:0] pend, input int ptr);
    logic [1:0] sh;
    for (int k = 0; k < 2; k++) begin
      sh = pend >> ((ptr + k) % 2);
      if (sh[0]) return (ptr + k) % 2;
    end
    return -1;
  endfunction

  task automatic host_xfer(input int ack_dly, input int xfer_len,
                           input logic [1:0] nxt_rd, input logic [1:0] nxt_wr,
                           output int g);
    logic [1:0]  oh, t;
    logic        exp_rd;
    logic [31:0] exp_lba;
    logic [7:0]  din_exp;
    int n;
    g       = model_pick(req_rd | req_wr, ptr_m);
    if (g < 0) g = 0;
    t       = req_rd >> g;
    exp_rd  = t[0];
    oh      = 2'b01 << g;
    exp_lba = lba_m[g];
    n = 0;
    while ((sd_rd | sd_wr) == 2'b00 && n < 20) begin
      @(negedge clk_sys);
      n++;
    end
    check_eq("grant_wait", 32'((sd_rd | sd_wr) != 2'b00), 32'd1);
    check_eq("grant_rd", 32'(sd_rd), 32'(exp_rd ? oh : 2'b00));
    check_eq("grant_wr", 32'(sd_wr), 32'(exp_rd ? 2'b00 : oh));
    check_eq("grant_lba", sd_lba, exp_lba);
    repeat (ack_dly) @(negedge clk_sys);
    check_eq("strobe_hold", 32'(sd_rd | sd_wr), 32'(oh));
    sd_ack = 1'b1;
    @(negedge clk_sys);
    check_eq("strobe_drop", 32'(sd_rd | sd_wr), 32'd0);
    check_eq("req_ack", 32'(req_ack), 32'(oh));
    for (int i = 0; i < xfer_len; i++) begin
      sd_buff_wr   = 1'($urandom_range(0, 1));
      sd_buff_addr = 9'($urandom);
      sd_buff_dout = 8'($urandom);
      req_buff_din = 16'($urandom);
      #1;
      din_exp = (g == 1) ? req_buff_din[15:8] : req_buff_din[7:0];
      check_eq("buff_din", 32'(sd_buff_din), 32'(din_exp));
      check_eq("buff_wr", 32'(req_buff_wr), 32'(sd_buff_wr ? oh : 2'b00));
      check_eq("buff_addr", 32'(buff_addr), 32'(sd_buff_addr));
      check_eq("buff_dout", 32'(buff_dout), 32'(sd_buff_dout));
      @(negedge clk_sys);
    end
    sd_buff_wr = 1'b0;
    req_rd     = nxt_rd;
    req_wr     = nxt_wr;
    lba_m[0]   = $urandom;
    lba_m[1]   = $urandom;
    drive_lba();
    sd_ack     = 1'b0;
    @(negedge clk_sys);
    check_eq("done_pulse", 32'(req_done), 32'(oh));
    @(negedge clk_sys);
    check_eq("done_clear", 32'(req_done), 32'd0);
    ptr_m = (g + 1) % 2;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int g;
    logic [1:0] r, w;
    reset_n = 1'b0;
    req_rd = '0; req_wr = '0; sd_ack = 1'b0; sd_buff_wr = 1'b0;
    sd_buff_addr = '0; sd_buff_dout = '0; req_buff_din = '0;
    lba_m[0] = '0; lba_m[1] = '0;
    drive_lba();
    repeat (3) @(negedge clk_sys);
    check_eq("rst_sd_rd", 32'(sd_rd), 32'd0);
    check_eq("rst_sd_wr", 32'(sd_wr), 32'd0);
    check_eq("rst_sd_lba", sd_lba, 32'd0);
    check_eq("rst_done", 32'(req_done), 32'd0);
    check_eq("rst_err", 32'(req_err), 32'd0);
    reset_n = 1'b1;
    mon_en  = 1'b1;
    @(negedge clk_sys);

    // Single read on requester 0.
    lba_m[0] = 32'h12345678;
    drive_lba();
    req_rd = 2'b01;
    @(negedge clk_sys);
    check_eq("first_rd", 32'(sd_rd), 32'h1);
    check_eq("first_lba", sd_lba, 32'h12345678);
    host_xfer(2, 3, 2'b00, 2'b00, g);

    // Write data steering to requester 1.
    req_wr = 2'b10;
    req_buff_din = {8'hA5, 8'h3C};
    @(negedge clk_sys);
    check_eq("steer_wr", 32'(sd_wr), 32'h2);
    check_eq("steer_rd", 32'(sd_rd), 32'h0);
    sd_ack = 1'b1; sd_buff_addr = 9'd5; sd_buff_wr = 1'b1; sd_buff_dout = 8'h5A;
    #1;
    check_eq("steer_din", 32'(sd_buff_din), 32'hA5);
    check_eq("steer_bwr", 32'(req_buff_wr), 32'h2);
    check_eq("steer_addr", 32'(buff_addr), 32'd5);
    check_eq("steer_dout", 32'(buff_dout), 32'h5A);
    @(negedge clk_sys);
    sd_buff_wr = 1'b0; req_wr = 2'b00; sd_ack = 1'b0;
    @(negedge clk_sys);
    check_eq("steer_done", 32'(req_done), 32'h2);
    @(negedge clk_sys);
    ptr_m = 0;

    // Round robin with both requesters reading continuously.
    req_rd = 2'b11;
    for (int k = 0; k < 4; k++) begin
      host_xfer(int'($urandom_range(0, 4)), int'($urandom_range(1, 3)),
                (k < 3) ? 2'b11 : 2'b00, 2'b00, g);
      check_eq("rr_order", 32'(g), 32'(k % 2));
    end

    // Withdrawal before ack.
    req_rd = 2'b01;
    @(negedge clk_sys);
    check_eq("wd_grant", 32'(sd_rd), 32'h1);
    req_rd = 2'b00;
    @(negedge clk_sys);
    check_eq("wd_drop", 32'(sd_rd), 32'h0);
    repeat (3) begin
      @(negedge clk_sys);
      check_eq("wd_no_done", 32'(req_done), 32'h0);
    end
    req_rd = 2'b11;
    host_xfer(1, 1, 2'b00, 2'b00, g);
    check_eq("wd_ptr", 32'(g), 32'd0);

    // Timeout: ack never arrives.
    req_rd = 2'b01;
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk_sys);
      check_eq("tmo_rd", 32'(sd_rd), 32'((k <= 17) ? 2'b01 : 2'b00));
      check_eq("tmo_err", 32'(req_err), 32'((k == 18) ? 2'b01 : 2'b00));
    end
    ptr_m  = 1;
    req_rd = 2'b11;
    host_xfer(0, 1, 2'b00, 2'b00, g);
    check_eq("tmo_ptr", 32'(g), 32'd1);

    // Stale ack held high in IDLE.
    sd_ack = 1'b1;
    req_rd = 2'b01;
    repeat (3) begin
      @(negedge clk_sys);
      check_eq("stale_hold", 32'(sd_rd | sd_wr), 32'h0);
    end
    sd_ack = 1'b0;
    @(negedge clk_sys);
    check_eq("stale_grant", 32'(sd_rd), 32'h1);
    host_xfer(1, 1, 2'b00, 2'b00, g);

    // Randomized traffic.
    r = 2'($urandom); w = 2'($urandom);
    if ((r | w) == 2'b00) r = 2'b10;
    req_rd = r; req_wr = w;
    for (int it = 0; it < 30; it++) begin
      r = 2'($urandom); w = 2'($urandom);
      if ((r | w) == 2'b00) w = 2'b01;
      if (it == 29) begin r = 2'b00; w = 2'b00; end
      host_xfer(int'($urandom_range(0, 10)), int'($urandom_range(1, 4)), r, w, g);
    end

    // Asynchronous reset during XFER.
    req_rd = 2'b01;
    @(negedge clk_sys);
    sd_ack = 1'b1;
    @(negedge clk_sys);
    req_rd = 2'b00;
    req_wr = 2'b10;
    lba_m[1] = 32'hCAFE0001;
    drive_lba();
    #2 reset_n = 1'b0;
    #1;
    check_eq("arst_rd", 32'(sd_rd), 32'h0);
    check_eq("arst_wr", 32'(sd_wr), 32'h0);
    check_eq("arst_lba", sd_lba, 32'h0);
    check_eq("arst_ack", 32'(req_ack), 32'h0);
    check_eq("arst_done", 32'(req_done), 32'h0);
    check_eq("arst_din", 32'(sd_buff_din), 32'h0);
    @(negedge clk_sys);
    sd_ack = 1'b0;
    @(negedge clk_sys);
    reset_n = 1'b1;
    ptr_m   = 0;
    @(negedge clk_sys);
    check_eq("arst_regrant_wr", 32'(sd_wr), 32'h2);
    check_eq("arst_regrant_rd", 32'(sd_rd), 32'h0);
    check_eq("arst_no_done", 32'(req_done), 32'h0);
    host_xfer(0, 2, 2'b00, 2'b00, g);

    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sd_drive_arbiter.md
Name: sd_drive_arbiter

Overview:
- Shares the single SD block-level channel of the HPS I/O block between NREQ core-side virtual-drive requesters.
- Grants one requester at a time using round-robin order, then drives the one-hot sd_rd/sd_wr vector and sd_lba toward the HPS I/O block.
- Sequences each transfer through the sd_ack handshake and steers sector-buffer traffic to the granted requester.
- Sits between the core's disk controllers and the HPS I/O block, which is instantiated with VDNUM=NREQ.

Parameters:
- NREQ, 2, number of requesters / virtual drives, legal range 1-4.
- WIDE, 0, 0 = 8-bit sector buffer (DW=7, AW=8); 1 = 16-bit sector buffer (DW=15, AW=7).
- TIMEOUT, 0, cycles to wait for sd_ack rise before aborting a grant; 0 disables the timeout.

Ports:
- clk_sys  in  1  system clock; all logic on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_lba  in  32*NREQ  per-requester LBA; slice i = [32*i+31:32*i].
- req_rd  in  NREQ  per-requester read request, level.
- req_wr  in  NREQ  per-requester write request, level.
- req_ack  out  NREQ  one-hot; mirrors sd_ack for the granted requester.
- req_done  out  NREQ  one-cycle pulse when the requester's transfer completes.
- req_err  out  NREQ  one-cycle pulse when the requester's grant times out.
- req_buff_wr  out  NREQ  sd_buff_wr gated to the granted requester.
- req_buff_din  in  (DW+1)*NREQ  per-requester buffer read data.
- buff_addr  out  AW+1  sd_buff_addr, broadcast to all requesters.
- buff_dout  out  DW+1  sd_buff_dout, broadcast to all requesters.
- sd_lba  out  32  LBA presented to the HPS I/O block.
- sd_rd  out  NREQ  one-hot read strobe to the HPS I/O block.
- sd_wr  out  NREQ  one-hot write strobe to the HPS I/O block.
- sd_ack  in  1  HPS transfer acknowledge.
- sd_buff_addr  in  AW+1  HPS buffer address.
- sd_buff_dout  in  DW+1  HPS buffer write data.
- sd_buff_wr  in  1  HPS buffer write strobe.
- sd_buff_din  out  DW+1  buffer read data, muxed from the granted requester.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - state=IDLE, grant=0, rr pointer=0, timeout counter=0.
  - sd_rd, sd_wr, sd_lba, req_done and req_err are all 0.
  - Reset mid-transfer abandons the transfer and produces no done pulse.
- Pending set: pend[i] = req_rd[i] | req_wr[i].
- Operation type: if both req_rd[i] and req_wr[i] are high, read wins and the write stays pending for a later grant.
- IDLE:
  - If any pend bit is set, rr_pick selects the first pending index at or after the pointer, wrapping modulo NREQ.
  - Grant index, op and LBA are latched on that edge.
  - sd_rd[g] or sd_wr[g] is asserted on the same edge, i.e. the next cycle after the request is seen.
  - sd_lba is registered from req_lba[g].
  - Next state is REQ.
- REQ:
  - Holds sd_rd/sd_wr and sd_lba.
  - On sd_ack=1: drop sd_rd/sd_wr, go to XFER.
  - If the granted requester drops both its rd and wr before ack: drop the strobe, return to IDLE, no done pulse, pointer unchanged.
  - If TIMEOUT!=0 and the counter reaches TIMEOUT: drop the strobe, pulse req_err[g], go to IDLE, pointer = g+1.
- XFER:
  - Requester withdrawal is ignored.
  - On sd_ack=0 go to DONE.
- DONE:
  - Pulse req_done[g] for exactly 1 cycle.
  - Pointer = (g+1) mod NREQ; next state is IDLE.
  - The next grant is possible no earlier than the cycle after DONE.
- Datapath, combinational, valid in REQ/XFER/DONE only:
  - req_ack = sd_ack ? onehot(g) : 0.
  - req_buff_wr = sd_buff_wr ? onehot(g) : 0.
  - sd_buff_din = req_buff_din slice g.
  - In IDLE: req_ack=0, req_buff_wr=0, sd_buff_din=0.
- sd_ack already high while in IDLE (stale): ignored; no grant is issued until it is low.
- At most one bit of sd_rd|sd_wr is high in any cycle (invariant).
- NREQ=1: the pointer is a constant 0.

Decomposition:
- Shared include sd_arb_defs.vh:
  - state encodings IDLE/REQ/XFER/DONE (2 bits);
  - DW/AW derivation from WIDE;
  - pointer width localparam ($clog2 of NREQ, minimum 1).
- Sub-module rr_pick: inputs NREQ-bit request vector and pointer; outputs valid and index. Purely combinational, unit-tested on its own.

Test Plan:
- Single read: req_rd[0]=1, lba=0x12345678.
  - Next cycle sd_rd=01 and sd_lba=0x12345678.
  - After sd_ack 0→1, sd_rd=00.
  - After sd_ack 1→0, req_done=01 for 1 cycle.
- Round-robin: req_rd=11 held continuously. Grants must alternate 0,1,0,1 over four transfers; no requester is starved.
- Write data steering (NREQ=2):
  - Grant 1 for write, sd_buff_addr=5, req_buff_din[1]=0xA5, req_buff_din[0]=0x3C.
  - sd_buff_din must read 0xA5.
  - An HPS write strobe appears only on req_buff_wr[1].
- Withdrawal: req_rd[0] dropped in REQ before ack → sd_rd=00 next cycle, no req_done, pointer still 0.
- Timeout: TIMEOUT=16, ack never arrives → req_err[0] pulses at cycle 17 after grant; sd_rd drops.
- Async reset asserted during XFER → all outputs 0 immediately; after release, a pending req_wr[1] is granted with sd_wr=10.
